// File: rtl/rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rob_ctrl
//  Purpose  : Control stage for the reorder-buffer register collection.
//             Hands out entry indices in program order, steers out-of-order
//             completions into their entries with one-hot write strobes, and
//             retires occupied entries strictly in order from the head,
//             clearing their occupancy as they leave.
//  Ports    :
//    clk, rst              clock, synchronous active-high reset
//    alloc_val/rdy/idx     entry allocation handshake, granted index = tail
//    cmp_val/idx/data      completion write (always accepted, checked)
//    deq_val/rdy/msg/idx   in-order retire handshake from the head entry
//    wr_data, wr_data_in   one-hot write strobe + shared payload to collection
//    clr_occ               one-hot occupancy clear to collection
//    data_out, occ         entry payloads and occupancy from collection
//    count                 allocated-but-not-retired entries (0..p_depth)
//    err                   sticky illegal-completion flag
//  Revision : 1.0 - initial release
// ============================================================================
module rob_ctrl #(
   parameter int p_depth    = 32,               // power of 2, >= 2
   parameter int p_ptrwidth = $clog2(p_depth),
   parameter int p_bitwidth = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  alloc_val,
   output logic                  alloc_rdy,
   output logic [p_ptrwidth-1:0] alloc_idx,

   input  logic                  cmp_val,
   input  logic [p_ptrwidth-1:0] cmp_idx,
   input  logic [p_bitwidth-1:0] cmp_data,

   output logic                  deq_val,
   input  logic                  deq_rdy,
   output logic [p_bitwidth-1:0] deq_msg,
   output logic [p_ptrwidth-1:0] deq_idx,

   output logic [p_depth-1:0]    wr_data,
   output logic [p_bitwidth-1:0] wr_data_in,
   output logic [p_depth-1:0]    clr_occ,
   input  logic [p_bitwidth-1:0] data_out [p_depth],
   input  logic [p_depth-1:0]    occ,

   output logic [p_ptrwidth:0]   count,
   output logic                  err
);

   localparam logic [p_ptrwidth:0]   c_DEPTH   = (p_ptrwidth+1)'(p_depth);
   localparam logic [p_ptrwidth-1:0] c_PTR_ONE = p_ptrwidth'(1);
   localparam logic [p_ptrwidth:0]   c_CNT_ONE = (p_ptrwidth+1)'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [p_ptrwidth-1:0] r_head;
   logic [p_ptrwidth-1:0] r_tail;
   logic [p_ptrwidth:0]   r_count;
   logic                  r_err;

   // ------------------------------------------------------------------------
   // Allocation: full is decided from the registered count only, so a retire
   // in the same cycle never opens a slot until the following cycle.
   // ------------------------------------------------------------------------
   logic w_alloc_rdy;
   logic w_alloc_fire;

   assign w_alloc_rdy  = !rst && (r_count < c_DEPTH);
   assign w_alloc_fire = alloc_val && w_alloc_rdy;

   // ------------------------------------------------------------------------
   // Completion check. The distance from head, taken modulo the depth by the
   // natural wrap of the pointer-width subtraction, must fall inside the live
   // window, and the entry must not already hold a result. An entry retiring
   // this cycle is still marked occupied, so completing it is rejected.
   // ------------------------------------------------------------------------
   logic [p_ptrwidth-1:0] w_cmp_off;
   logic                  w_cmp_in_window;
   logic                  w_cmp_legal;
   logic                  w_cmp_write;
   logic                  w_cmp_illegal;

   assign w_cmp_off       = cmp_idx - r_head;
   assign w_cmp_in_window = ({1'b0, w_cmp_off} < r_count);
   assign w_cmp_legal     = w_cmp_in_window && !occ[cmp_idx];
   assign w_cmp_write     = !rst && cmp_val && w_cmp_legal;
   assign w_cmp_illegal   = cmp_val && !w_cmp_legal;

   // ------------------------------------------------------------------------
   // Retire: only the registered occupancy of the head is consulted, so a
   // completion landing on the head this cycle retires next cycle at the
   // earliest.
   // ------------------------------------------------------------------------
   logic w_deq_val;
   logic w_deq_fire;

   assign w_deq_val  = !rst && (r_count != '0) && occ[r_head];
   assign w_deq_fire = w_deq_val && deq_rdy;

   // ------------------------------------------------------------------------
   // One-hot strobe decoders towards the collection
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < p_depth; gi++) begin : g_strobe
      assign wr_data[gi] = w_cmp_write && (cmp_idx == p_ptrwidth'(gi));
      assign clr_occ[gi] = w_deq_fire  && (r_head  == p_ptrwidth'(gi));
   end

   // ------------------------------------------------------------------------
   // Pointer, count and error registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_alloc_fire) begin
            r_tail <= r_tail + c_PTR_ONE;
         end
         if (w_deq_fire) begin
            r_head <= r_head + c_PTR_ONE;
         end
         // Simultaneous alloc and retire cancel out.
         case ({w_alloc_fire, w_deq_fire})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_cmp_illegal) begin
            r_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign alloc_rdy  = w_alloc_rdy;
   assign alloc_idx  = r_tail;
   assign deq_val    = w_deq_val;
   assign deq_msg    = data_out[r_head];
   assign deq_idx    = r_head;
   assign wr_data_in = cmp_data;
   assign count      = r_count;
   assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_ctrl
//  Purpose  : Self-checking bench for rob_ctrl (p_depth = 4) with a
//             behavioural model of the register collection and a retire
//             scoreboard of expected indices/payloads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rob_ctrl;

   localparam int c_DEPTH = 4;
   localparam int c_PW    = 2;
   localparam int c_BW    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              alloc_val;
   logic              alloc_rdy;
   logic [c_PW-1:0]   alloc_idx;
   logic              cmp_val;
   logic [c_PW-1:0]   cmp_idx;
   logic [c_BW-1:0]   cmp_data;
   logic              deq_val;
   logic              deq_rdy;
   logic [c_BW-1:0]   deq_msg;
   logic [c_PW-1:0]   deq_idx;
   logic [c_DEPTH-1:0] wr_data;
   logic [c_BW-1:0]   wr_data_in;
   logic [c_DEPTH-1:0] clr_occ;
   logic [c_BW-1:0]   coll_mem [c_DEPTH];
   logic [c_DEPTH-1:0] coll_occ;
   logic [c_PW:0]     count;
   logic              err;

   rob_ctrl #(
      .p_depth    (c_DEPTH),
      .p_ptrwidth (c_PW),
      .p_bitwidth (c_BW)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .alloc_val  (alloc_val),
      .alloc_rdy  (alloc_rdy),
      .alloc_idx  (alloc_idx),
      .cmp_val    (cmp_val),
      .cmp_idx    (cmp_idx),
      .cmp_data   (cmp_data),
      .deq_val    (deq_val),
      .deq_rdy    (deq_rdy),
      .deq_msg    (deq_msg),
      .deq_idx    (deq_idx),
      .wr_data    (wr_data),
      .wr_data_in (wr_data_in),
      .clr_occ    (clr_occ),
      .data_out   (coll_mem),
      .occ        (coll_occ),
      .count      (count),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Register collection model
   always @(posedge clk) begin
      if (rst) begin
         coll_occ <= '0;
      end else begin
         for (int i = 0; i < c_DEPTH; i++) begin
            if (wr_data[i]) begin
               coll_mem[i] <= wr_data_in;
               coll_occ[i] <= 1'b1;
            end
            if (clr_occ[i]) coll_occ[i] <= 1'b0;
         end
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard state
   logic [c_PW-1:0] m_tail;
   logic [c_PW-1:0] exp_q [$];
   logic [c_BW-1:0] exp_data [c_DEPTH];
   int              ret_cyc [$];
   int              n_retired = 0;
   int              cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Retire monitor: every accepted retire must match the oldest allocation.
   always @(negedge clk) begin
      if (!rst && deq_val && deq_rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_retire", 64'(deq_idx), 64'hFFFF);
         end else begin
            logic [c_PW-1:0]    f_idx;
            logic [c_DEPTH-1:0] f_oh;
            f_idx = exp_q.pop_front();
            f_oh  = 4'b0001 << f_idx;
            check("ret_idx", 64'(deq_idx), 64'(f_idx));
            check("ret_msg", 64'(deq_msg), 64'(exp_data[f_idx]));
            check("ret_clr", 64'(clr_occ), 64'(f_oh));
            n_retired++;
            ret_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc_val = 1'b0;
      cmp_val = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      m_tail = '0;
      exp_q.delete();
      ret_cyc.delete();
   endtask

   task automatic alloc_one();
      alloc_val = 1'b1;
      @(negedge clk);
      check("alloc_rdy", 64'(alloc_rdy), 64'd1);
      check("alloc_idx", 64'(alloc_idx), 64'(m_tail));
      exp_q.push_back(m_tail);
      m_tail = m_tail + 1'b1;
      tick();
      alloc_val = 1'b0;
   endtask

   task automatic complete(input logic [c_PW-1:0] idx, input logic [c_BW-1:0] data);
      logic [c_DEPTH-1:0] oh;
      oh = 4'b0001 << idx;
      cmp_val = 1'b1;
      cmp_idx = idx;
      cmp_data = data;
      exp_data[idx] = data;
      @(negedge clk);
      check("cmp_wr", 64'(wr_data), 64'(oh));
      check("cmp_wr_in", 64'(wr_data_in), 64'(data));
      tick();
      cmp_val = 1'b0;
   endtask

   task automatic wait_retired(input int target, input int budget);
      for (int i = 0; i < budget && n_retired < target; i++) tick();
      check("retire_count", 64'(n_retired), 64'(target));
   endtask

   initial begin
      int base;
      rst = 1'b1; alloc_val = 1'b0; cmp_val = 1'b0; cmp_idx = '0;
      cmp_data = '0; deq_rdy = 1'b0; m_tail = '0;

      // ---- reset: inputs active while rst is held ----
      tick();
      alloc_val = 1'b1; cmp_val = 1'b1; cmp_idx = 2'd2; deq_rdy = 1'b1;
      @(negedge clk);
      check("rst_alloc_rdy", 64'(alloc_rdy), 64'd0);
      check("rst_deq_val", 64'(deq_val), 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      check("rst_clr_occ", 64'(clr_occ), 64'd0);
      tick();
      rst = 1'b0; alloc_val = 1'b0; cmp_val = 1'b0; deq_rdy = 1'b0;
      @(negedge clk);
      check("post_rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
      check("post_rst_alloc_idx", 64'(alloc_idx), 64'd0);
      check("post_rst_count", 64'(count), 64'd0);
      check("post_rst_err", 64'(err), 64'd0);
      tick();

      // ---- in-order ----
      deq_rdy = 1'b1;
      base = n_retired;
      alloc_one(); alloc_one(); alloc_one();
      complete(2'd0, 32'hA0);
      complete(2'd1, 32'hA1);
      complete(2'd2, 32'hA2);
      wait_retired(base + 3, 20);
      @(negedge clk);
      check("inord_count", 64'(count), 64'd0);
      check("inord_deq_val", 64'(deq_val), 64'd0);
      tick();

      // ---- out-of-order ----
      do_reset();
      deq_rdy = 1'b1;
      alloc_one(); alloc_one(); alloc_one(); alloc_one();
      complete(2'd3, 32'hB3);
      complete(2'd1, 32'hB1);
      complete(2'd2, 32'hB2);
      @(negedge clk);
      check("ooo_deq_val", 64'(deq_val), 64'd0);
      tick();
      base = n_retired;
      ret_cyc.delete();
      complete(2'd0, 32'hB0);
      wait_retired(base + 4, 20);
      check("ooo_consec", (ret_cyc.size() >= 4) ? 64'(ret_cyc[3] - ret_cyc[0]) : 64'hFFFF, 64'd3);

      // ---- full / wrap / backpressure ----
      do_reset();
      deq_rdy = 1'b0;
      alloc_one(); alloc_one(); alloc_one(); alloc_one();
      alloc_val = 1'b1;
      @(negedge clk);
      check("full_alloc_rdy", 64'(alloc_rdy), 64'd0);
      check("full_count", 64'(count), 64'd4);
      tick();
      complete(2'd0, 32'hC0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_deq_val", 64'(deq_val), 64'd1);
         check("bp_deq_msg", 64'(deq_msg), 64'hC0);
         check("bp_clr_occ", 64'(clr_occ), 64'd0);
         check("bp_deq_idx", 64'(deq_idx), 64'd0);
         tick();
      end
      deq_rdy = 1'b1;
      @(negedge clk);
      check("nobypass_alloc_rdy", 64'(alloc_rdy), 64'd0);
      tick();
      deq_rdy = 1'b0;
      alloc_val = 1'b0;
      @(negedge clk);
      check("wrap_count", 64'(count), 64'd3);
      tick();
      alloc_one();
      @(negedge clk);
      check("refull_count", 64'(count), 64'd4);
      tick();

      // ---- illegal completions ----
      do_reset();
      cmp_val = 1'b1; cmp_idx = 2'd2; cmp_data = 32'hDEAD;
      @(negedge clk);
      check("ill_wr_data", 64'(wr_data), 64'd0);
      tick();
      cmp_val = 1'b0;
      @(negedge clk);
      check("ill_err", 64'(err), 64'd1);
      repeat (3) tick();
      @(negedge clk);
      check("ill_err_sticky", 64'(err), 64'd1);
      tick();
      do_reset();
      @(negedge clk);
      check("err_cleared", 64'(err), 64'd0);
      tick();
      alloc_one();
      complete(2'd0, 32'h55);
      @(negedge clk);
      check("legal_err", 64'(err), 64'd0);
      tick();
      cmp_val = 1'b1; cmp_idx = 2'd0; cmp_data = 32'h66;
      @(negedge clk);
      check("dbl_wr_data", 64'(wr_data), 64'd0);
      tick();
      cmp_val = 1'b0;
      @(negedge clk);
      check("dbl_err", 64'(err), 64'd1);
      check("dbl_payload", 64'(coll_mem[0]), 64'h55);
      check("dbl_deq_msg", 64'(deq_msg), 64'h55);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
